// File: rtl/fetch_sequencer.sv
// Fetch/issue/update sequencer steering the 6-bit program counter.
// Fetches over req/ack, offers the IR over valid/ready, then commits the PC.
module fetch_sequencer #(
  parameter int unsigned AW       = 6,
  parameter int unsigned IW       = 8,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  output logic          pc_inc,
  output logic          pc_we,
  output logic [AW-1:0] pc_offset,
  output logic [AW-1:0] imem_addr,
  output logic          imem_req,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_rdata,
  output logic [IW-1:0] ir,
  output logic          ir_valid,
  input  logic          exec_ready,
  input  logic          zero_flag,
  output logic          halted,
  output logic          fault
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_UPDATE,
    S_HALT,
    S_FAULT
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [1:0]      ir_class;
  logic            is_halt;
  logic            taken;

  assign ir_class = ir_q[IW-1:IW-2];
  assign is_halt  = (ir_class == 2'b11) && (ir_q[AW-1:0] == {AW{1'b1}});
  assign taken    = (ir_class == 2'b10) || ((ir_class == 2'b01) && zero_flag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (imem_ack) begin
          ir_d       = imem_rdata;
          wait_cnt_d = '0;
          state_d    = S_ISSUE;
        end else if (wait_cnt_q == CW'(MAX_WAIT - 1)) begin
          wait_cnt_d = CW'(MAX_WAIT);
          state_d    = S_FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      S_ISSUE: begin
        if (exec_ready) state_d = S_UPDATE;
      end
      S_UPDATE: state_d = is_halt ? S_HALT : S_FETCH;
      S_HALT:   state_d = S_HALT;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_inc    = 1'b0;
    pc_we     = 1'b0;
    pc_offset = '0;
    imem_addr = '0;
    imem_req  = 1'b0;
    ir_valid  = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc;
      end
      S_ISSUE:  ir_valid = 1'b1;
      S_UPDATE: begin
        pc_we     = 1'b1;
        pc_offset = ir_q[AW-1:0];
        pc_inc    = !taken;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

  assign ir = ir_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: holds the PC register, serves instructions, and
// compares against a transaction-level model of the program flow.
module tb_fetch_sequencer;

  localparam int unsigned AW       = 6;
  localparam int unsigned IW       = 8;
  localparam int unsigned MAX_WAIT = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc;
  logic          pc_inc, pc_we;
  logic [AW-1:0] pc_offset, imem_addr;
  logic          imem_req;
  logic          imem_ack = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic [IW-1:0] ir;
  logic          ir_valid;
  logic          exec_ready = 1'b0;
  logic          zero_flag = 1'b0;
  logic          halted, fault;

  int total = 0;
  int bad   = 0;
  int mpc   = 0;

  fetch_sequencer #(.AW(AW), .IW(IW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc        (pc),
    .pc_inc    (pc_inc),
    .pc_we     (pc_we),
    .pc_offset (pc_offset),
    .imem_addr (imem_addr),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .exec_ready(exec_ready),
    .zero_flag (zero_flag),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // PC datapath the sequencer steers.
  always @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else if (pc_we) pc <= pc_inc ? pc + 6'd1 : pc + 6'd1 + pc_offset;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit br_taken(input logic [7:0] ins, input bit z);
    return (ins[7:6] == 2'b10) || (ins[7:6] == 2'b01 && z);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},    imem_req,  0);
    chk({tag, "_addr"},   imem_addr, 0);
    chk({tag, "_we"},     pc_we,     0);
    chk({tag, "_inc"},    pc_inc,    0);
    chk({tag, "_off"},    pc_offset, 0);
    chk({tag, "_valid"},  ir_valid,  0);
    chk({tag, "_halted"}, halted,    0);
    chk({tag, "_fault"},  fault,     0);
    chk({tag, "_ir"},     ir,        0);
  endtask

  // Reset, release, and step into the first FETCH cycle.
  task automatic reset_and_start;
    rst        = 1'b1;
    imem_ack   = 1'b0;
    exec_ready = 1'b0;
    tick;
    tick;
    chk_all_zero("rst");
    rst = 1'b0;
    mpc = 0;
    chk("idle_req", imem_req, 0);
    tick;
  endtask

  // One instruction, entered in its first FETCH cycle and left in the next
  // FETCH cycle (or first HALT cycle).
  task automatic run_instr(input logic [7:0] ins, input bit z, input int ad, input int rd);
    bit exp_taken;
    chk("fetch_req",  imem_req,  1);
    chk("fetch_addr", imem_addr, mpc);
    for (int i = 0; i < ad; i++) begin
      imem_ack = 1'b0;
      tick;
      chk("wait_req",   imem_req,  1);
      chk("wait_addr",  imem_addr, mpc);
      chk("wait_fault", fault,     0);
    end
    imem_ack   = 1'b1;
    imem_rdata = ins;
    tick;
    imem_ack   = 1'b0;
    imem_rdata = 8'($urandom);
    chk("issue_valid", ir_valid, 1);
    chk("issue_ir",    ir,       ins);
    chk("issue_req",   imem_req, 0);
    for (int i = 0; i < rd; i++) begin
      exec_ready = 1'b0;
      tick;
      chk("stall_valid", ir_valid, 1);
      chk("stall_ir",    ir,       ins);
      chk("stall_we",    pc_we,    0);
    end
    exec_ready = 1'b1;
    zero_flag  = z;
    tick;
    exec_ready = 1'b0;
    exp_taken  = br_taken(ins, z);
    chk("upd_we",    pc_we,     1);
    chk("upd_inc",   pc_inc,    !exp_taken);
    chk("upd_off",   pc_offset, ins[5:0]);
    chk("upd_valid", ir_valid,  0);
    mpc = (mpc + 1 + (exp_taken ? int'(ins[5:0]) : 0)) % 64;
    tick;
    zero_flag = 1'($urandom);
    chk("pc_after", pc, mpc);
    chk("we_once",  pc_we, 0);
  endtask

  initial begin
    logic [7:0] ins;

    // Latency path: immediate ack and ready.
    reset_and_start;
    run_instr(8'h05, 1'b0, 0, 0);
    // Jumps, self-loop, wrap, branch-on-zero.
    run_instr(8'b10_000010, 1'b0, 0, 0);   // 1 -> 4
    run_instr(8'b10_000011, 1'b0, 1, 0);   // 4 -> 8
    run_instr(8'b10_000001, 1'b1, 0, 1);   // 8 -> 10
    run_instr(8'hBF, 1'b0, 0, 0);          // 10 -> 10
    chk("self_loop", mpc, 10);
    run_instr(8'hBF, 1'b1, 2, 0);
    run_instr(8'b10_110100, 1'b0, 0, 0);   // 10 -> 63
    chk("at_63", mpc, 63);
    run_instr(8'b10_000001, 1'b0, 0, 0);   // 63 -> 1 (wrap)
    chk("wrap", mpc, 1);
    run_instr(8'b01_000010, 1'b0, 0, 0);   // not taken -> 2
    run_instr(8'b01_000010, 1'b1, 0, 0);   // taken -> 5
    run_instr(8'h07, 1'b0, 0, 5);          // long stall
    run_instr(8'h11, 1'b0, MAX_WAIT - 1, 0); // ack on the last allowed cycle

    for (int n = 0; n < 40; n++) begin
      ins = 8'($urandom);
      if (ins == 8'hFF) ins = 8'h3F;
      run_instr(ins, 1'($urandom), int'($urandom_range(0, MAX_WAIT - 1)),
                int'($urandom_range(0, 3)));
    end
    run_instr(8'h5A, 1'b0, 0, 0);

    // Asynchronous reset in the middle of a fetch.
    imem_ack = 1'b0;
    tick;
    chk("mid_req", imem_req, 1);
    rst = 1'b1;
    #1;
    chk_all_zero("async");
    tick;

    // Fetch timeout.
    reset_and_start;
    for (int i = 0; i < int'(MAX_WAIT); i++) begin
      chk("to_req",   imem_req, 1);
      chk("to_fault", fault,    0);
      tick;
    end
    chk("to_fault_set", fault,    1);
    chk("to_req_off",   imem_req, 0);
    imem_ack   = 1'b1;
    exec_ready = 1'b1;
    tick;
    chk("fault_sticky", fault, 1);
    chk("fault_no_req", imem_req, 0);
    chk("fault_no_we",  pc_we, 0);
    imem_ack   = 1'b0;
    exec_ready = 1'b0;

    // HALT retires once, then everything stops.
    reset_and_start;
    run_instr(8'h01, 1'b0, 0, 0);
    run_instr(8'b10_000100, 1'b0, 0, 0);   // 1 -> 6
    run_instr(8'hFF, 1'b1, 1, 1);          // HALT at 6, PC -> 7
    chk("halt_pc", mpc, 7);
    for (int i = 0; i < 4; i++) begin
      chk("halted",   halted,   1);
      chk("halt_req", imem_req, 0);
      chk("halt_we",  pc_we,    0);
      chk("halt_pcv", pc,       7);
      imem_ack   = 1'($urandom);
      exec_ready = 1'($urandom);
      tick;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
